// File: rtl/cve2_rvfi_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : cve2_rvfi_trace_buf
// Brief    : Triggered RVFI retirement capture with FWFT drain FIFO and drop accounting.
// Revision : 1.0 - initial release
// ============================================================================
module cve2_rvfi_trace_buf #(
    parameter int unsigned Depth  = 16,
    parameter int unsigned OrderW = 16,
    localparam int unsigned RecW  = OrderW + 103,
    localparam int unsigned LvlW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            rvfi_valid,
    input  logic [63:0]     rvfi_order,
    input  logic [31:0]     rvfi_insn,
    input  logic            rvfi_trap,
    input  logic            rvfi_intr,
    input  logic [31:0]     rvfi_pc_rdata,
    input  logic [4:0]      rvfi_rd_addr,
    input  logic [31:0]     rvfi_rd_wdata,
    input  logic            arm_i,
    input  logic            flush_i,
    input  logic [31:0]     trig_pc_i,
    input  logic            trig_any_i,
    input  logic            traps_only_i,
    input  logic [15:0]     post_cnt_i,
    output logic            rec_valid_o,
    input  logic            rec_ready_i,
    output logic [RecW-1:0] rec_data_o,
    output logic [LvlW-1:0] level_o,
    output logic [1:0]      state_o,
    output logic [15:0]     drop_cnt_o,
    output logic            overflow_o
);

    localparam int unsigned AW = $clog2(Depth);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     post_q, post_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LvlW-1:0] level_q;
    logic [15:0]     drop_q;
    logic            ovf_q;
    logic [RecW-1:0] mem_q [Depth];

    logic            w_hit, w_cand, w_full, w_pop_raw, w_push, w_pop, w_drop;
    logic [15:0]     w_post, w_cnt_inc;
    logic [RecW-1:0] w_rec;

    generate
        if (OrderW < 64) begin : g_order_hi
            logic w_unused_order;
            assign w_unused_order = ^rvfi_order[63:OrderW];
        end
    endgenerate

    assign w_hit  = rvfi_valid & (trig_any_i | (rvfi_pc_rdata == trig_pc_i));
    assign w_cand = rvfi_valid
                  & ((state_q == ST_CAPTURE) | ((state_q == ST_ARMED) & w_hit))
                  & (~traps_only_i | rvfi_trap | rvfi_intr);

    // The trigger cycle uses the live post count and restarts the counter.
    assign w_post    = (state_q == ST_ARMED) ? post_cnt_i : post_q;
    assign w_cnt_inc = ((state_q == ST_ARMED) ? 16'd0 : cnt_q) + 16'(w_cand);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        post_d  = post_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        state_d = ST_ARMED;
                        cnt_d   = 16'd0;
                    end
                end
                ST_ARMED: begin
                    if (w_hit) begin
                        state_d = ST_CAPTURE;
                        post_d  = post_cnt_i;
                        cnt_d   = w_cnt_inc;
                        if (w_cand && (w_post != 16'd0) && (w_cnt_inc == w_post)) state_d = ST_DONE;
                    end
                end
                ST_CAPTURE: begin
                    cnt_d = w_cnt_inc;
                    if (w_cand && (w_post != 16'd0) && (w_cnt_inc == w_post)) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            post_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            post_q  <= post_d;
        end
    end

    assign w_full    = (level_q == LvlW'(Depth));
    assign w_pop_raw = rec_valid_o & rec_ready_i;
    assign w_pop     = w_pop_raw & ~flush_i;
    assign w_push    = w_cand & (~w_full | w_pop_raw) & ~flush_i;
    assign w_drop    = w_cand & w_full & ~w_pop_raw & ~flush_i;

    assign w_rec = {rvfi_order[OrderW-1:0], rvfi_pc_rdata, rvfi_insn,
                    rvfi_rd_addr, rvfi_rd_wdata, rvfi_trap, rvfi_intr};

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wptr_q] <= w_rec;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            drop_q  <= 16'd0;
            ovf_q   <= 1'b0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            drop_q  <= 16'd0;
            ovf_q   <= 1'b0;
        end else begin
            if (w_push) wptr_q <= wptr_q + AW'(1);
            if (w_pop)  rptr_q <= rptr_q + AW'(1);
            if (w_push && !w_pop)      level_q <= level_q + LvlW'(1);
            else if (!w_push && w_pop) level_q <= level_q - LvlW'(1);
            if (w_drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign rec_valid_o = (level_q != '0);
    assign rec_data_o  = rec_valid_o ? mem_q[rptr_q] : '0;
    assign level_o     = level_q;
    assign state_o     = state_q;
    assign drop_cnt_o  = drop_q;
    assign overflow_o  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cve2_rvfi_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_cve2_rvfi_trace_buf
// Brief    : Directed self-checking bench for cve2_rvfi_trace_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cve2_rvfi_trace_buf;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned OW    = 16;
    localparam int unsigned RW    = OW + 103;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rvfi_valid = 1'b0;
    logic [63:0]   rvfi_order = '0;
    logic [31:0]   rvfi_insn = '0;
    logic          rvfi_trap = 1'b0;
    logic          rvfi_intr = 1'b0;
    logic [31:0]   rvfi_pc_rdata = '0;
    logic [4:0]    rvfi_rd_addr = '0;
    logic [31:0]   rvfi_rd_wdata = '0;
    logic          arm_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [31:0]   trig_pc_i = '0;
    logic          trig_any_i = 1'b0;
    logic          traps_only_i = 1'b0;
    logic [15:0]   post_cnt_i = '0;
    logic          rec_valid_o;
    logic          rec_ready_i = 1'b0;
    logic [RW-1:0] rec_data_o;
    logic [4:0]    level_o;
    logic [1:0]    state_o;
    logic [15:0]   drop_cnt_o;
    logic          overflow_o;

    int errors = 0;
    int checks = 0;
    logic [RW-1:0] popped [$];

    cve2_rvfi_trace_buf #(.Depth(DEPTH), .OrderW(OW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .arm_i(arm_i), .flush_i(flush_i), .trig_pc_i(trig_pc_i), .trig_any_i(trig_any_i),
        .traps_only_i(traps_only_i), .post_cnt_i(post_cnt_i),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_data_o(rec_data_o),
        .level_o(level_o), .state_o(state_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Pops are decided at the next rising edge; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_ni && rec_valid_o && rec_ready_i && !flush_i) popped.push_back(rec_data_o);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ord_of(input logic [RW-1:0] r);
        return r[RW-1 -: OW];
    endfunction

    function automatic logic [31:0] pc_of(input logic [RW-1:0] r);
        return r[102:71];
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [63:0] ord, input logic trap, input logic intr);
        rvfi_valid    = 1'b1;
        rvfi_pc_rdata = pc;
        rvfi_order    = ord;
        rvfi_insn     = pc ^ 32'h13;
        rvfi_rd_addr  = ord[4:0];
        rvfi_rd_wdata = ~pc;
        rvfi_trap     = trap;
        rvfi_intr     = intr;
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic pulse_arm();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    initial begin
        logic [31:0] pcs [5];
        pcs[0] = 32'h7C; pcs[1] = 32'h80; pcs[2] = 32'h84; pcs[3] = 32'h88; pcs[4] = 32'h8C;

        #12;
        check("rst_state", state_o, 2'd0);
        check("rst_level", level_o, 5'd0);
        check("rst_valid", rec_valid_o, 1'b0);
        check("rst_drop", drop_cnt_o, 16'd0);
        check("rst_ovf", overflow_o, 1'b0);
        rst_ni = 1'b1;
        tick();

        // Test 1: PC trigger with post count 3
        trig_pc_i = 32'h80; post_cnt_i = 16'd3; rec_ready_i = 1'b1;
        pulse_arm();
        check("t1_armed", state_o, 2'd1);
        for (int i = 0; i < 5; i++) begin
            drive(pcs[i], 64'(i), 1'b0, 1'b0);
            tick();
            if (i == 1) check("t1_capture", state_o, 2'd2);
        end
        rvfi_valid = 1'b0;
        repeat (3) tick();
        check("t1_done", state_o, 2'd3);
        check("t1_npop", popped.size(), 3);
        if (popped.size() == 3) begin
            check("t1_pc0", pc_of(popped[0]), 32'h80);
            check("t1_pc1", pc_of(popped[1]), 32'h84);
            check("t1_pc2", pc_of(popped[2]), 32'h88);
        end
        check("t1_level", level_o, 5'd0);

        // Test 2: overflow with no consumer
        pulse_flush();
        popped.delete();
        rec_ready_i = 1'b0; trig_any_i = 1'b1; post_cnt_i = 16'd0;
        pulse_arm();
        for (int i = 0; i < 20; i++) begin
            drive(32'h1000 + 32'(4 * i), 64'(i), 1'b0, 1'b0);
            tick();
        end
        rvfi_valid = 1'b0;
        check("t2_level", level_o, 5'd16);
        check("t2_drop", drop_cnt_o, 16'd4);
        check("t2_ovf", overflow_o, 1'b1);
        check("t2_head", ord_of(rec_data_o), 16'd0);

        // Test 3: push and pop together while full
        drive(32'h2000, 64'd100, 1'b0, 1'b0);
        rec_ready_i = 1'b1;
        tick();
        rvfi_valid = 1'b0;
        check("t3_level", level_o, 5'd16);
        check("t3_drop", drop_cnt_o, 16'd4);
        repeat (18) tick();
        check("t3_npop", popped.size(), 17);
        if (popped.size() == 17) begin
            check("t3_first", ord_of(popped[0]), 16'd0);
            check("t3_pen", ord_of(popped[15]), 16'd15);
            check("t3_tail", ord_of(popped[16]), 16'd100);
        end
        check("t3_empty", rec_valid_o, 1'b0);

        // Test 4: traps-only filtering with post count 2
        pulse_flush();
        popped.delete();
        rec_ready_i = 1'b0; traps_only_i = 1'b1; post_cnt_i = 16'd2;
        pulse_arm();
        for (int i = 1; i <= 5; i++) begin
            drive(32'h3000 + 32'(4 * i), 64'(i), i == 2, i == 4);
            tick();
            if (i == 4) check("t4_done", state_o, 2'd3);
        end
        rvfi_valid = 1'b0;
        check("t4_level", level_o, 5'd2);
        check("t4_head", ord_of(rec_data_o), 16'd2);
        check("t4_trapbit", rec_data_o[1:0], 2'b10);
        rec_ready_i = 1'b1;
        tick();
        rec_ready_i = 1'b0;
        check("t4_second", ord_of(rec_data_o), 16'd4);
        check("t4_intrbit", rec_data_o[1:0], 2'b01);

        // Test 5: flush and arm together mid-capture
        pulse_flush();
        traps_only_i = 1'b0; post_cnt_i = 16'd0;
        pulse_arm();
        for (int i = 0; i < 18; i++) begin
            drive(32'h4000, 64'(i), 1'b0, 1'b0);
            tick();
        end
        rvfi_valid = 1'b0;
        check("t5_drop_pre", drop_cnt_o, 16'd2);
        rec_ready_i = 1'b1;
        repeat (11) tick();
        rec_ready_i = 1'b0;
        check("t5_level_pre", level_o, 5'd5);
        check("t5_state_pre", state_o, 2'd2);
        flush_i = 1'b1; arm_i = 1'b1; rec_ready_i = 1'b1;
        drive(32'h4000, 64'd50, 1'b0, 1'b0);
        tick();
        flush_i = 1'b0; arm_i = 1'b0; rec_ready_i = 1'b0; rvfi_valid = 1'b0;
        check("t5_state", state_o, 2'd0);
        check("t5_level", level_o, 5'd0);
        check("t5_drop", drop_cnt_o, 16'd0);
        check("t5_ovf", overflow_o, 1'b0);

        // Test 6: drop counter saturation
        pulse_arm();
        drive(32'h5000, 64'd7, 1'b0, 1'b0);
        repeat (16 + 65534) tick();
        check("t6_fffe", drop_cnt_o, 16'hFFFE);
        repeat (3) tick();
        check("t6_sat", drop_cnt_o, 16'hFFFF);
        check("t6_level", level_o, 5'd16);

        // Asynchronous reset while capturing
        #3 rst_ni = 1'b0;
        #1;
        check("ar_state", state_o, 2'd0);
        check("ar_level", level_o, 5'd0);
        check("ar_drop", drop_cnt_o, 16'd0);
        check("ar_ovf", overflow_o, 1'b0);
        rvfi_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
